// File: rtl/phase_bus_pkg.sv
// Shared definitions for the phase-bus card responder: port map, broadcast
// board code, responder FSM states and active-low strobe levels.
package phase_bus_pkg;

  localparam logic [2:0] PORT_MUX      = 3'd3;
  localparam logic [2:0] PORT_ADC_HIGH = 3'd4;
  localparam logic [2:0] PORT_ADC_LOW  = 3'd5;
  localparam logic [2:0] PORT_STATUS   = 3'd7;

  // Board code that addresses every card at once (writes only).
  localparam int PB_BOARD_ALL = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR_LOW,
    RD_DRIVE,
    TEST_DRIVE,
    RECOVER,
    PROTO_ERR
  } resp_state_e;

  // Bus strobes are active low.
  typedef enum logic {
    ENABLE  = 1'b0,
    DISABLE = 1'b1
  } strobe_level_e;

  // Increment that sticks at the top of the 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pb_sync2.sv
// Two-flop synchroniser for one bus input bit or bus; RST_VAL lets idle-high
// strobes come out of reset in their inactive level.
module pb_sync2 #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/phase_bus_card_responder.sv
// Card-side responder for the phase-bus handshake: board decode, 8-entry port
// register file, read/test-address drive and strobe-width checking.
// Optional feature macro: PB_RESPONDER_ADC_EN (mux/ADC convert emulation).
module phase_bus_card_responder
  import phase_bus_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BOARD_ID        = 0,
  parameter int BOARD_ALL       = PB_BOARD_ALL,
  parameter int MIN_STROBE      = 4,
  parameter int CONV_CYCLES     = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] BOARD_X,
  input  logic [2:0] AddessPortPin,
  input  logic       RdP,
  input  logic       WrP,
  input  logic       TestAddressP,
  input  logic [7:0] Data_In_Port,
  output logic [7:0] Data_Out_Port,
  output logic       data_drive_en,
  output logic       write_pulse,
  output logic [2:0] last_write_port,
  output logic       adc_busy,
  output logic [7:0] strobe_err_count
);

  localparam logic [3:0] ID4   = 4'(BOARD_ID);
  localparam logic [3:0] ALL4  = 4'(BOARD_ALL);
  localparam logic [4:0] MIN_W = 5'(MIN_STROBE);

  // The clock frequency is informational; a nonsensical value gets an empty marker block.
  if (CLOCK_FREQUENCY <= 0) begin : g_bad_clock_frequency
  end

  logic [3:0] board_s;
  logic [2:0] addr_s;
  logic       rd_s, wr_s, test_s;
  logic [7:0] data_s;

  pb_sync2 #(.W(4), .RST_VAL(4'h0))  u_sync_board (.clock(clock), .reset(reset), .d_i(BOARD_X),       .q_o(board_s));
  pb_sync2 #(.W(3), .RST_VAL(3'h0))  u_sync_addr  (.clock(clock), .reset(reset), .d_i(AddessPortPin), .q_o(addr_s));
  pb_sync2 #(.W(1), .RST_VAL(1'b1))  u_sync_rd    (.clock(clock), .reset(reset), .d_i(RdP),           .q_o(rd_s));
  pb_sync2 #(.W(1), .RST_VAL(1'b1))  u_sync_wr    (.clock(clock), .reset(reset), .d_i(WrP),           .q_o(wr_s));
  pb_sync2 #(.W(1), .RST_VAL(1'b1))  u_sync_test  (.clock(clock), .reset(reset), .d_i(TestAddressP),  .q_o(test_s));
  pb_sync2 #(.W(8), .RST_VAL(8'h00)) u_sync_data  (.clock(clock), .reset(reset), .d_i(Data_In_Port),  .q_o(data_s));

  logic rd_low, wr_low, test_low, both_low, sel_own, sel_wr;
  assign rd_low   = (rd_s == ENABLE);
  assign wr_low   = (wr_s == ENABLE);
  assign test_low = (test_s == ENABLE);
  assign both_low = rd_low && wr_low;
  assign sel_own  = (board_s == ID4);
  assign sel_wr   = sel_own || (board_s == ALL4);

  resp_state_e state_q, state_d;
  logic [4:0]  width_q, width_d;
  logic [7:0]  wdata_q;
  logic [7:0]  regs_q [8];
  logic        commit, err_inc, wr_accept, reg_we, port_writable;
  logic        adc_load;
  logic [15:0] adc_result;
  logic [7:0]  rd_word, dout_d;

  // Next-state decode, strobe-width tracking and write/error decisions.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    commit  = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_wr && wr_low) begin
          state_d = WR_LOW;
          width_d = 5'd1;
        end else if (sel_own && rd_low) begin
          state_d = RD_DRIVE;
          width_d = 5'd1;
        end else if (sel_own && test_low) begin
          state_d = TEST_DRIVE;
        end
      end
      WR_LOW: begin
        if (both_low)    state_d = PROTO_ERR;
        else if (!sel_wr) state_d = RECOVER;
        else if (wr_low) width_d = (width_q == 5'd31) ? width_q : width_q + 5'd1;
        else begin
          state_d = RECOVER;
          if (width_q >= MIN_W) commit  = 1'b1;
          else                  err_inc = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (both_low)      state_d = PROTO_ERR;
        else if (!sel_own) state_d = RECOVER;
        else if (rd_low)   width_d = (width_q == 5'd31) ? width_q : width_q + 5'd1;
        else begin
          state_d = RECOVER;
          if (width_q < MIN_W) err_inc = 1'b1;
        end
      end
      TEST_DRIVE: begin
        if (both_low)                  state_d = PROTO_ERR;
        else if (!sel_own || !test_low) state_d = RECOVER;
      end
      RECOVER: state_d = both_low ? PROTO_ERR : IDLE;
      PROTO_ERR: begin
        if (!rd_low && !wr_low && !test_low) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != PROTO_ERR) && (state_d == PROTO_ERR)) err_inc = 1'b1;
  end

`ifdef PB_RESPONDER_ADC_EN
  // ADC result ports are loaded only by the converter.
  assign port_writable = (addr_s != PORT_STATUS) && (addr_s != PORT_ADC_HIGH) && (addr_s != PORT_ADC_LOW);
`else
  assign port_writable = (addr_s != PORT_STATUS);
`endif
  assign wr_accept = commit && (addr_s != PORT_STATUS);
  assign reg_we    = wr_accept && port_writable;

  // Read data source: status word or addressed register; drive value by next state.
  always_comb begin
    rd_word = (addr_s == PORT_STATUS) ? {adc_busy, 4'b0000, ID4[2:0]} : regs_q[addr_s];
    dout_d  = 8'h00;
    if (state_d == RD_DRIVE)        dout_d = rd_word;
    else if (state_d == TEST_DRIVE) dout_d = {ID4, addr_s, 1'b1};
  end

  // FSM, sampled write data, registered bus outputs and error counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= IDLE;
      width_q          <= '0;
      wdata_q          <= '0;
      Data_Out_Port    <= '0;
      data_drive_en    <= 1'b0;
      write_pulse      <= 1'b0;
      last_write_port  <= '0;
      strobe_err_count <= '0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      if (state_d == WR_LOW) wdata_q <= data_s;
      Data_Out_Port <= dout_d;
      data_drive_en <= (state_d == RD_DRIVE) || (state_d == TEST_DRIVE);
      write_pulse   <= wr_accept;
      if (wr_accept) last_write_port <= addr_s;
      if (err_inc)   strobe_err_count <= sat_inc8(strobe_err_count);
    end
  end

  // Port register file: bus writes plus converter result loads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      if (reg_we) regs_q[addr_s] <= wdata_q;
      if (adc_load) begin
        regs_q[PORT_ADC_HIGH] <= adc_result[15:8];
        regs_q[PORT_ADC_LOW]  <= adc_result[7:0];
      end
    end
  end

`ifdef PB_RESPONDER_ADC_EN
  logic        busy_q, mux_latched_q, adc_start;
  logic [15:0] conv_cnt_q;
  logic [9:0]  sample_q;
  logic [3:0]  mux_cap_q;

  assign adc_start  = wr_accept && mux_latched_q && !busy_q;
  assign adc_load   = busy_q && (conv_cnt_q == 16'd0);
  assign adc_result = {mux_cap_q, ID4[1:0], sample_q};
  assign adc_busy   = busy_q;

  // Conversion timer: busy for CONV_CYCLES clocks, then publish and bump the sample count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q        <= 1'b0;
      mux_latched_q <= 1'b0;
      conv_cnt_q    <= '0;
      sample_q      <= '0;
      mux_cap_q     <= '0;
    end else begin
      if (reg_we && (addr_s == PORT_MUX)) mux_latched_q <= 1'b1;
      if (adc_start) begin
        busy_q     <= 1'b1;
        conv_cnt_q <= 16'(CONV_CYCLES - 1);
        mux_cap_q  <= regs_q[PORT_MUX][3:0];
      end else if (busy_q) begin
        if (conv_cnt_q == 16'd0) begin
          busy_q   <= 1'b0;
          sample_q <= sample_q + 10'd1;
        end else begin
          conv_cnt_q <= conv_cnt_q - 16'd1;
        end
      end
    end
  end
`else
  assign adc_load   = 1'b0;
  assign adc_result = '0;
  assign adc_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_phase_bus_card_responder.sv
// Directed bench: four responder cards (BOARD_ID 0..3) on one shared bus.
module tb_phase_bus_card_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] BOARD_X;
  logic [2:0] AddessPortPin;
  logic       RdP, WrP, TestAddressP;
  logic [7:0] Data_In_Port;

  logic [7:0] dout [4];
  logic [3:0] drv, wpulse, busy;
  logic [2:0] lwp  [4];
  logic [7:0] errc [4];

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 4; gi++) begin : g_card
    phase_bus_card_responder #(.BOARD_ID(gi)) u_dut (
      .clock           (clock),
      .reset           (reset),
      .BOARD_X         (BOARD_X),
      .AddessPortPin   (AddessPortPin),
      .RdP             (RdP),
      .WrP             (WrP),
      .TestAddressP    (TestAddressP),
      .Data_In_Port    (Data_In_Port),
      .Data_Out_Port   (dout[gi]),
      .data_drive_en   (drv[gi]),
      .write_pulse     (wpulse[gi]),
      .last_write_port (lwp[gi]),
      .adc_busy        (busy[gi]),
      .strobe_err_count(errc[gi])
    );
  end

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) if (wpulse[i]) pulse_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input string tag, input logic [3:0] bx, input logic [2:0] a,
                           input logic [7:0] d, input int low, input logic [3:0] exp_pulse);
    BOARD_X = bx; AddessPortPin = a; Data_In_Port = d;
    @(negedge clock);
    WrP = 1'b0;
    repeat (low) @(negedge clock);
    WrP = 1'b1;
    repeat (3) @(negedge clock);
    check({tag, ".pulse"}, 32'(wpulse), 32'(exp_pulse));
    $display("write %s: board=%0d port=%0d data=%02h low=%0d pulses=%b", tag, bx, a, d, low, wpulse);
  endtask

  task automatic bus_read(input string tag, input int k, input logic [3:0] bx,
                          input logic [2:0] a, input logic [7:0] exp_d);
    logic [3:0] mask;
    mask = (k >= 0) ? 4'(1 << k) : 4'b0000;
    BOARD_X = bx; AddessPortPin = a;
    @(negedge clock);
    RdP = 1'b0;
    repeat (2) @(negedge clock);
    check({tag, ".early"}, 32'(drv), 32'(0));
    @(negedge clock);
    check({tag, ".drv"}, 32'(drv), 32'(mask));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s.data%0d", tag, i), 32'(dout[i]), 32'((i == k) ? exp_d : 8'h00));
    repeat (3) @(negedge clock);
    RdP = 1'b1;
    repeat (2) @(negedge clock);
    check({tag, ".hold"}, 32'(drv), 32'(mask));
    @(negedge clock);
    check({tag, ".release"}, 32'(drv), 32'(0));
    $display("read  %s: board=%0d port=%0d expect=%02h card=%0d", tag, bx, a, exp_d, k);
  endtask

  initial begin
    reset = 1'b0; BOARD_X = 4'hF; AddessPortPin = 3'd0;
    RdP = 1'b1; WrP = 1'b1; TestAddressP = 1'b1; Data_In_Port = 8'h00;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst.dout%0d", i), 32'(dout[i]), 32'(0));
      check($sformatf("rst.lwp%0d", i),  32'(lwp[i]),  32'(0));
      check($sformatf("rst.err%0d", i),  32'(errc[i]), 32'(0));
    end
    check("rst.drv", 32'(drv), 32'(0));
    check("rst.pulse", 32'(wpulse), 32'(0));
    check("rst.busy", 32'(busy), 32'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);
    $display("reset released");

    // Own-board write then read back.
    bus_write("wr.a5", 4'd1, 3'd2, 8'hA5, 8, 4'b0010);
    check("wr.a5.lwp", 32'(lwp[1]), 32'(2));
    bus_read("rd.a5", 1, 4'd1, 3'd2, 8'hA5);
    check("wr.a5.count", 32'(pulse_cnt[1]), 32'(1));

    // Broadcast write lands on all cards; broadcast read drives nothing.
    bus_write("wr.bcast", 4'd5, 3'd3, 8'h07, 8, 4'b1111);
    check("wr.bcast.lwp0", 32'(lwp[0]), 32'(3));
    for (int i = 0; i < 4; i++) bus_read($sformatf("rd.bcast%0d", i), i, 4'(i), 3'd3, 8'h07);
    bus_read("rd.bcastsel", -1, 4'd5, 3'd3, 8'h00);

    // Short write strobe is discarded and counted.
    bus_write("wr.short", 4'd1, 3'd2, 8'hFF, 2, 4'b0000);
    check("wr.short.err", 32'(errc[1]), 32'(1));
    bus_read("rd.short", 1, 4'd1, 3'd2, 8'hA5);

    // RdP and WrP low together.
    BOARD_X = 4'd1; AddessPortPin = 3'd2;
    @(negedge clock);
    RdP = 1'b0; WrP = 1'b0;
    repeat (4) @(negedge clock);
    check("proto.drv", 32'(drv), 32'(0));
    check("proto.err", 32'(errc[1]), 32'(2));
    repeat (3) @(negedge clock);
    check("proto.err.hold", 32'(errc[1]), 32'(2));
    check("proto.drv.hold", 32'(drv), 32'(0));
    RdP = 1'b1; WrP = 1'b1;
    repeat (4) @(negedge clock);
    check("proto.count", 32'(pulse_cnt[1]), 32'(2));
    $display("proto error sequence done, err1=%0d", errc[1]);
    bus_read("rd.proto", 1, 4'd1, 3'd2, 8'hA5);

    // Test-address echo.
    BOARD_X = 4'd2; AddessPortPin = 3'd6;
    @(negedge clock);
    TestAddressP = 1'b0;
    repeat (3) @(negedge clock);
    check("test.drv", 32'(drv), 32'(4'b0100));
    check("test.data", 32'(dout[2]), 32'(8'h2D));
    repeat (2) @(negedge clock);
    TestAddressP = 1'b1;
    repeat (3) @(negedge clock);
    check("test.release", 32'(drv), 32'(0));
    $display("test-address echo board=2 port=6");

    // Status port reads ID and ignores writes.
    bus_read("rd.status", 3, 4'd3, 3'd7, 8'h03);
    bus_write("wr.status", 4'd3, 3'd7, 8'h55, 6, 4'b0000);
    bus_read("rd.status2", 3, 4'd3, 3'd7, 8'h03);

    // Deselect while WrP is low: no write, no error.
    BOARD_X = 4'd0; AddessPortPin = 3'd0; Data_In_Port = 8'h33;
    @(negedge clock);
    WrP = 1'b0;
    repeat (5) @(negedge clock);
    BOARD_X = 4'hF;
    repeat (3) @(negedge clock);
    WrP = 1'b1;
    repeat (4) @(negedge clock);
    check("desel.err", 32'(errc[0]), 32'(0));
    check("desel.count", 32'(pulse_cnt[0]), 32'(1));
    $display("deselect mid-strobe done");
    bus_read("rd.desel", 0, 4'd0, 3'd0, 8'h00);

    // Reset while driving a read.
    BOARD_X = 4'd1; AddessPortPin = 3'd2;
    @(negedge clock);
    RdP = 1'b0;
    repeat (3) @(negedge clock);
    check("rstrd.drv", 32'(drv), 32'(4'b0010));
    check("rstrd.data", 32'(dout[1]), 32'(8'hA5));
    reset = 1'b0;
    @(negedge clock);
    check("rstrd.drv0", 32'(drv), 32'(0));
    check("rstrd.data0", 32'(dout[1]), 32'(0));
    check("rstrd.err0", 32'(errc[1]), 32'(0));
    check("rstrd.lwp0", 32'(lwp[1]), 32'(0));
    RdP = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    $display("reset during read done");
    for (int p = 0; p < 7; p++) bus_read($sformatf("rd.clr%0d", p), 1, 4'd1, 3'(p), 8'h00);

`ifdef PB_RESPONDER_ADC_EN
    bus_write("adc.mux", 4'd2, 3'd3, 8'h03, 6, 4'b0100);
    check("adc.mux.busy", 32'(busy), 32'(0));
    bus_write("adc.conv1", 4'd2, 3'd0, 8'h11, 6, 4'b0100);
    check("adc.conv1.busy", 32'(busy), 32'(4'b0100));
    repeat (19) @(negedge clock);
    check("adc.conv1.busy19", 32'(busy), 32'(4'b0100));
    @(negedge clock);
    check("adc.conv1.done", 32'(busy), 32'(0));
    bus_read("adc.hi1", 2, 4'd2, 3'd4, 8'h38);
    bus_read("adc.lo1", 2, 4'd2, 3'd5, 8'h00);
    bus_write("adc.conv2", 4'd2, 3'd0, 8'h22, 6, 4'b0100);
    check("adc.conv2.busy", 32'(busy), 32'(4'b0100));
    bus_read("adc.lo.busy", 2, 4'd2, 3'd5, 8'h00);
    repeat (12) @(negedge clock);
    check("adc.conv2.done", 32'(busy), 32'(0));
    bus_read("adc.lo2", 2, 4'd2, 3'd5, 8'h01);
    bus_read("adc.hi2", 2, 4'd2, 3'd4, 8'h38);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
